// File: rtl/gat_feat_readback.sv
// Streams the final GAT feature BRAM out over valid/ready, hiding BRAM read latency behind a credit-gated FIFO.
// Optional GAT_FEAT_NODE_LAST_EN: m_tlast marks every node's last feature instead of only the final word.
module gat_feat_readback #(
  parameter int TOP_WIDTH          = 32,
  parameter int NEW_FEATURE_WIDTH  = 32,
  parameter int NUM_SUBGRAPHS      = 2708,
  parameter int NUM_FEATURE_OUT    = 16,
  parameter int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS*NUM_FEATURE_OUT,
  parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
  parameter int BRAM_RD_LATENCY    = 2,
  parameter int FIFO_DEPTH         = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          gat_ready,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
  input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
  output logic [TOP_WIDTH-1:0]          m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast,
  output logic [NEW_FEATURE_ADDR_W:0]   beat_cnt
);

  localparam int AW = NEW_FEATURE_ADDR_W;
  localparam int L  = BRAM_RD_LATENCY;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(NEW_FEATURE_DEPTH - 1);

  typedef enum logic [2:0] {IDLE, WAIT_RDY, ISSUE, DRAIN, DONE} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [AW+1:0]   addr_q, addr_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]     beat_q, beat_d;
  logic [L:1]      vld_q, vld_d, lst_q, lst_d;

  logic [NEW_FEATURE_WIDTH-1:0] fifo_mem  [FIFO_DEPTH];
  logic                         fifo_last [FIFO_DEPTH];

  logic        credit_ok, issue, push, pop, tag, start_acc;
  logic [CW:0] occ_sum;

`ifdef GAT_FEAT_NODE_LAST_EN
  localparam int FW = (NUM_FEATURE_OUT > 1) ? $clog2(NUM_FEATURE_OUT) : 1;
  logic [FW-1:0] feat_q, feat_d;
  // Running position within the node; avoids a modulo on the word index.
  assign tag = (feat_q == FW'(NUM_FEATURE_OUT - 1));
  always_comb begin
    feat_d = feat_q;
    if (start_acc)  feat_d = '0;
    else if (issue) feat_d = tag ? '0 : feat_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) feat_q <= '0;
    else        feat_q <= feat_d;
`else
  assign tag = (idx_q == LAST_IDX);
`endif

  // Credit counts both reads still in the BRAM pipe and words already queued.
  assign occ_sum   = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
  assign credit_ok = occ_sum < (CW+1)'(FIFO_DEPTH);
  assign issue     = (state_q == ISSUE) && credit_ok;
  assign push      = vld_q[L];
  assign m_tvalid  = (fifo_cnt_q != '0);
  assign pop       = m_tvalid && m_tready;
  assign start_acc = (state_q == IDLE) && start;

  assign busy            = (state_q != IDLE);
  assign done            = (state_q == DONE);
  assign beat_cnt        = beat_q;
  assign feat_bram_addrb = issue ? {idx_q, 2'b00} : addr_q;
  assign m_tlast         = m_tvalid && fifo_last[rptr_q];

  always_comb begin
    m_tdata = '0;
    if (m_tvalid) m_tdata[NEW_FEATURE_WIDTH-1:0] = fifo_mem[rptr_q];
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    addr_d     = feat_bram_addrb;
    inflight_d = inflight_q;
    fifo_cnt_d = fifo_cnt_q;
    wptr_d     = wptr_q + PW'(push);
    rptr_d     = rptr_q + PW'(pop);
    beat_d     = beat_q;
    vld_d      = '0;
    lst_d      = '0;
    vld_d[1]   = issue;
    lst_d[1]   = tag;
    for (int k = 2; k <= L; k++) begin
      vld_d[k] = vld_q[k-1];
      lst_d[k] = lst_q[k-1];
    end

    case (state_q)
      IDLE:     if (start) begin
                  state_d = WAIT_RDY;
                  idx_d   = '0;
                end
      WAIT_RDY: if (gat_ready) state_d = ISSUE;
      ISSUE:    if (issue) begin
                  idx_d = idx_q + 1'b1;
                  if (idx_q == LAST_IDX) state_d = DRAIN;
                end
      DRAIN:    if (inflight_q == '0 && fifo_cnt_q == '0) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    case ({issue, push})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    if (start_acc) beat_d = '0;
    else if (pop)  beat_d = beat_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      addr_q     <= '0;
      inflight_q <= '0;
      fifo_cnt_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      beat_q     <= '0;
      vld_q      <= '0;
      lst_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      beat_q     <= beat_d;
      vld_q      <= vld_d;
      lst_q      <= lst_d;
    end
  end

  // Storage only; occupancy and pointers above decide what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wptr_q]  <= feat_bram_dout;
      fifo_last[wptr_q] <= lst_q[L];
    end
  end

endmodule

// File: tb/tb_gat_feat_readback.sv
// Self-checking bench for gat_feat_readback: small 4x4 feature map, randomized data and backpressure.
module tb_gat_feat_readback;
  localparam int NS = 4, NFO = 4, DEPTH = NS*NFO, AW = 4, L = 2, FD = 8;

  logic        clk = 1'b0, rst_n = 1'b0, gat_ready = 1'b0, start = 1'b0, m_tready = 1'b0;
  logic        busy, done, m_tvalid, m_tlast;
  logic [AW+1:0] feat_bram_addrb;
  logic [31:0] feat_bram_dout, m_tdata;
  logic [AW:0] beat_cnt;

  int n_cmp = 0, n_err = 0;
  logic [31:0] mem [DEPTH];
  logic [AW+1:0] apipe [L];

  always #5 clk = ~clk;

  gat_feat_readback #(
    .TOP_WIDTH(32), .NEW_FEATURE_WIDTH(32), .NUM_SUBGRAPHS(NS), .NUM_FEATURE_OUT(NFO),
    .BRAM_RD_LATENCY(L), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .gat_ready(gat_ready), .start(start), .busy(busy), .done(done),
    .feat_bram_addrb(feat_bram_addrb), .feat_bram_dout(feat_bram_dout),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .beat_cnt(beat_cnt)
  );

  // BRAM model: data for the byte address seen L edges ago.
  always @(posedge clk) begin
    apipe[0] <= feat_bram_addrb;
    for (int k = 1; k < L; k++) apipe[k] <= apipe[k-1];
  end
  assign feat_bram_dout = mem[apipe[L-1][AW+1:2]];

  function automatic logic exp_last(input int i);
`ifdef GAT_FEAT_NODE_LAST_EN
    return (i % NFO) == NFO - 1;
`else
    return i == DEPTH - 1;
`endif
  endfunction

  task automatic fill_mem(input bit ramp);
    for (int i = 0; i < DEPTH; i++) mem[i] = ramp ? 32'(i) : $urandom;
  endtask

  // Leaves the bench at the falling edge of cycle 1 (start sampled at the end of cycle 0).
  task automatic pulse_start;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; gat_ready = 1'b0; start = 1'b0; m_tready = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, feat_bram_addrb, m_tvalid, m_tdata, m_tlast, beat_cnt} !== '0) begin
      n_err++;
      $display("FAIL reset_values: got busy=%b done=%b addr=%h v=%b d=%h l=%b cnt=%0d, want all 0",
               busy, done, feat_bram_addrb, m_tvalid, m_tdata, m_tlast, beat_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic ev;
    fill_mem(1'b1); gat_ready = 1'b1; m_tready = 1'b1;
    pulse_start;
    for (int c = 1; c <= 26; c++) begin
      if (c == 1) begin
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_c1: got %b want 1", busy); end
      end
      if (c >= 2 && c <= 17) begin
        n_cmp++;
        if (feat_bram_addrb !== 6'((c-2)*4)) begin
          n_err++; $display("FAIL basic_addr c=%0d: got %h want %h", c, feat_bram_addrb, 6'((c-2)*4));
        end
      end
      ev = (c >= 5 && c <= 20);
      n_cmp++;
      if (m_tvalid !== ev) begin n_err++; $display("FAIL basic_valid c=%0d: got %b want %b", c, m_tvalid, ev); end
      if (ev) begin
        n_cmp++;
        if (m_tdata !== mem[c-5] || m_tlast !== exp_last(c-5)) begin
          n_err++; $display("FAIL basic_beat %0d: got d=%h l=%b want d=%h l=%b",
                            c-5, m_tdata, m_tlast, mem[c-5], exp_last(c-5));
        end
      end
      n_cmp++;
      if (done !== (c == 22)) begin n_err++; $display("FAIL basic_done c=%0d: got %b want %b", c, done, c == 22); end
      if (c == 23) begin
        n_cmp++;
        if (busy !== 1'b0 || beat_cnt !== 5'(DEPTH)) begin
          n_err++; $display("FAIL basic_end: got busy=%b cnt=%0d want busy=0 cnt=%0d", busy, beat_cnt, DEPTH);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure;
    int got = 0, iss = 0;
    bit fin = 0, stall_prev = 0;
    logic [31:0] pd;
    logic pl;
    logic [AW+1:0] pa = 6'h3C;
    fill_mem(1'b0); gat_ready = 1'b1; m_tready = 1'b0;
    pulse_start;
    for (int c = 1; c < 500 && !fin; c++) begin
      if (feat_bram_addrb !== pa) iss++;
      pa = feat_bram_addrb;
      n_cmp++;
      if (iss - got > FD) begin n_err++; $display("FAIL bp_credit: outstanding %0d want <= %0d", iss - got, FD); end
      if (m_tvalid && stall_prev) begin
        n_cmp++;
        if (m_tdata !== pd || m_tlast !== pl) begin
          n_err++; $display("FAIL bp_stable: got d=%h l=%b want d=%h l=%b", m_tdata, m_tlast, pd, pl);
        end
      end
      m_tready = 1'($urandom_range(0, 1));
      if (m_tvalid && m_tready) begin
        n_cmp++;
        if (got >= DEPTH) begin
          n_err++; $display("FAIL bp_extra_beat: got beat %0d want at most %0d", got, DEPTH);
        end else if (m_tdata !== mem[got] || m_tlast !== exp_last(got)) begin
          n_err++; $display("FAIL bp_beat %0d: got d=%h l=%b want d=%h l=%b",
                            got, m_tdata, m_tlast, mem[got], exp_last(got));
        end
        got++;
      end
      stall_prev = m_tvalid && !m_tready; pd = m_tdata; pl = m_tlast;
      if (done) fin = 1;
      @(negedge clk);
    end
    n_cmp++;
    if (!fin || got != DEPTH || beat_cnt !== 5'(DEPTH)) begin
      n_err++; $display("FAIL bp_total: got done=%b beats=%0d cnt=%0d want 1/%0d/%0d", fin, got, beat_cnt, DEPTH, DEPTH);
    end
    m_tready = 1'b1;
  endtask

  task automatic test_stall;
    int got = 0;
    bit fin = 0;
    fill_mem(1'b0); gat_ready = 1'b1; m_tready = 1'b0;
    pulse_start;
    for (int c = 1; c <= 21; c++) begin
      if (c >= 2) begin
        n_cmp++;
        if (feat_bram_addrb !== 6'(4 * ((c-2) < 7 ? (c-2) : 7))) begin
          n_err++; $display("FAIL stall_addr c=%0d: got %h want %h", c, feat_bram_addrb, 6'(4 * ((c-2) < 7 ? (c-2) : 7)));
        end
      end
      @(negedge clk);
    end
    m_tready = 1'b1;
    for (int c = 0; c < 200 && !fin; c++) begin
      if (m_tvalid) begin
        n_cmp++;
        if (got >= DEPTH || m_tdata !== mem[got] || m_tlast !== exp_last(got)) begin
          n_err++; $display("FAIL stall_beat %0d: got d=%h l=%b want d=%h", got, m_tdata, m_tlast, mem[got % DEPTH]);
        end
        got++;
      end
      if (done) fin = 1;
      @(negedge clk);
    end
    n_cmp++;
    if (!fin || got != DEPTH) begin n_err++; $display("FAIL stall_total: got done=%b beats=%0d want 1/%0d", fin, got, DEPTH); end
  endtask

  task automatic test_gate;
    int got = 0;
    bit fin = 0;
    fill_mem(1'b0); gat_ready = 1'b0; m_tready = 1'b1;
    pulse_start;
    for (int c = 1; c <= 50; c++) begin
      n_cmp++;
      if (busy !== 1'b1 || feat_bram_addrb !== 6'h3C || m_tvalid !== 1'b0) begin
        n_err++; $display("FAIL gate_hold c=%0d: got busy=%b addr=%h v=%b want 1/3c/0", c, busy, feat_bram_addrb, m_tvalid);
      end
      @(negedge clk);
    end
    gat_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (feat_bram_addrb !== 6'h00) begin n_err++; $display("FAIL gate_issue: got addr %h want 00", feat_bram_addrb); end
    for (int c = 0; c < 200 && !fin; c++) begin
      if (m_tvalid) begin
        n_cmp++;
        if (got >= DEPTH || m_tdata !== mem[got] || m_tlast !== exp_last(got)) begin
          n_err++; $display("FAIL gate_beat %0d: got d=%h l=%b want d=%h", got, m_tdata, m_tlast, mem[got % DEPTH]);
        end
        got++;
      end
      if (done) fin = 1;
      @(negedge clk);
    end
    n_cmp++;
    if (!fin || got != DEPTH) begin n_err++; $display("FAIL gate_total: got done=%b beats=%0d want 1/%0d", fin, got, DEPTH); end
  endtask

  task automatic test_back_to_back;
    int got = 0;
    fill_mem(1'b0); gat_ready = 1'b1; m_tready = 1'b1;
    pulse_start;
    for (int c = 1; c <= 30; c++) begin
      start = (c == 19);
      if (m_tvalid) begin
        n_cmp++;
        if (got >= DEPTH || m_tdata !== mem[got] || m_tlast !== exp_last(got)) begin
          n_err++; $display("FAIL b2b_beat %0d: got d=%h l=%b want d=%h", got, m_tdata, m_tlast, mem[got % DEPTH]);
        end
        got++;
      end
      n_cmp++;
      if (done !== (c == 22)) begin n_err++; $display("FAIL b2b_done c=%0d: got %b want %b", c, done, c == 22); end
      if (c >= 23) begin
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_restart c=%0d: got busy=%b want 0", c, busy); end
      end
      @(negedge clk);
    end
    start = 1'b0;
    n_cmp++;
    if (got != DEPTH || beat_cnt !== 5'(DEPTH)) begin
      n_err++; $display("FAIL b2b_total: got beats=%0d cnt=%0d want %0d", got, beat_cnt, DEPTH);
    end
  endtask

  task automatic test_reset_mid;
    int got = 0;
    bit fin = 0;
    fill_mem(1'b0); gat_ready = 1'b1; m_tready = 1'b1;
    pulse_start;
    for (int c = 0; c < 100 && got < 5; c++) begin
      if (m_tvalid) got++;
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, feat_bram_addrb, m_tvalid, m_tdata, m_tlast, beat_cnt} !== '0) begin
      n_err++;
      $display("FAIL midreset_values: got busy=%b done=%b addr=%h v=%b d=%h l=%b cnt=%0d, want all 0",
               busy, done, feat_bram_addrb, m_tvalid, m_tdata, m_tlast, beat_cnt);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fill_mem(1'b0);
    pulse_start;
    got = 0;
    for (int c = 0; c < 200 && !fin; c++) begin
      if (m_tvalid) begin
        n_cmp++;
        if (got >= DEPTH || m_tdata !== mem[got] || m_tlast !== exp_last(got)) begin
          n_err++; $display("FAIL midreset_beat %0d: got d=%h l=%b want d=%h", got, m_tdata, m_tlast, mem[got % DEPTH]);
        end
        got++;
      end
      if (done) fin = 1;
      @(negedge clk);
    end
    n_cmp++;
    if (!fin || got != DEPTH || beat_cnt !== 5'(DEPTH)) begin
      n_err++; $display("FAIL midreset_total: got done=%b beats=%0d cnt=%0d want 1/%0d/%0d", fin, got, beat_cnt, DEPTH, DEPTH);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_stall;
    test_gate;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
